// File: rtl/mips_pkg.sv
// Shared register-file constants and the write-port arbiter state type.
package mips_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [REG_W-1:0] R0 = '0;

  typedef enum logic {
    WB_PRI = 1'b0,
    LU_PRI = 1'b1
  } rf_arb_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-result scoreboard: one bit per register with a long-latency write outstanding.
module rf_scoreboard
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_reg,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_reg,
  input  logic [REG_W-1:0] iss_reg,
  output logic             iss_pending,
  input  logic [REG_W-1:0] rs,
  output logic             rs_pending,
  input  logic [REG_W-1:0] rt,
  output logic             rt_pending
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // Set is applied after clear so a new issue overrides a same-cycle completion.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && set_reg != R0) set_mask[set_reg] = 1'b1;
    if (clr_en && clr_reg != R0) clr_mask[clr_reg] = 1'b1;
    pending_next = (pending & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_next;
  end

  assign iss_pending = pending[iss_reg];
  assign rs_pending  = pending[rs];
  assign rt_pending  = pending[rt];

endmodule

// File: rtl/rf_write_sched.sv
// Register-file write-port arbiter (WB vs long unit) with starvation guard and hazard scoreboard.
// Optional same-cycle bypass of long-unit results enabled by defining RF_SCHED_BYPASS_EN.
module rf_write_sched
  import mips_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              lu_valid,
  input  logic [REG_W-1:0]  lu_reg,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  input  logic              iss_valid,
  input  logic [REG_W-1:0]  iss_reg,
  output logic              iss_ready,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  output logic              hazard,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_wreg,
  output logic [DATA_W-1:0] rf_wdata
`ifdef RF_SCHED_BYPASS_EN
  ,
  output logic              byp_rs,
  output logic              byp_rt,
  output logic [DATA_W-1:0] byp_data
`endif
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  rf_arb_state_t     state, state_next;
  logic [CNT_W-1:0]  starve_cnt, cnt_next;
  logic              wr_en_c;
  logic [REG_W-1:0]  wr_reg_c;
  logic [DATA_W-1:0] wr_data_c;
  logic              iss_pending, rs_pending, rt_pending;

  // Grant selection, starvation counting and priority switching.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    wb_ready   = 1'b0;
    lu_ready   = 1'b0;
    case (state)
      WB_PRI: begin
        wb_ready = wb_valid;
        lu_ready = lu_valid && !wb_valid;
      end
      LU_PRI: begin
        lu_ready = lu_valid;
        wb_ready = wb_valid && !lu_valid;
      end
      default: ;
    endcase
    if (lu_valid && !lu_ready) begin
      cnt_next = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + CNT_W'(1);
      if (cnt_next == CNT_MAX) state_next = LU_PRI;
    end
    if (state == LU_PRI && lu_ready) state_next = WB_PRI;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WB_PRI;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= cnt_next;
    end
  end

  always_comb begin
    wr_reg_c  = wb_ready ? wb_reg  : lu_reg;
    wr_data_c = wb_ready ? wb_data : lu_data;
    wr_en_c   = (wb_ready || lu_ready) && wr_reg_c != R0;
  end

  // Write-port register; r0 writes are accepted but never reach the file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_wreg  <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wr_en_c;
      if (wr_en_c) begin
        rf_wreg  <= wr_reg_c;
        rf_wdata <= wr_data_c;
      end
    end
  end

  rf_scoreboard u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .set_en      (iss_valid && iss_ready),
    .set_reg     (iss_reg),
    .clr_en      (lu_ready),
    .clr_reg     (lu_reg),
    .iss_reg     (iss_reg),
    .iss_pending (iss_pending),
    .rs          (rs),
    .rs_pending  (rs_pending),
    .rt          (rt),
    .rt_pending  (rt_pending)
  );

  assign iss_ready = !iss_pending;

`ifdef RF_SCHED_BYPASS_EN
  assign byp_rs   = lu_ready && lu_reg != R0 && lu_reg == rs;
  assign byp_rt   = lu_ready && lu_reg != R0 && lu_reg == rt;
  assign byp_data = (byp_rs || byp_rt) ? lu_data : '0;
  assign hazard   = (rs != R0 && rs_pending && !byp_rs) ||
                    (rt != R0 && rt_pending && !byp_rt);
`else
  assign hazard   = (rs != R0 && rs_pending) || (rt != R0 && rt_pending);
`endif

endmodule

// File: tb/tb_rf_write_sched.sv
// Self-checking bench for rf_write_sched: directed scenarios then random traffic against a queue-free model.
module tb_rf_write_sched;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, lu_valid, iss_valid;
  logic [4:0]  wb_reg, lu_reg, iss_reg, rs, rt;
  logic [31:0] wb_data, lu_data;
  logic        wb_ready, lu_ready, iss_ready, hazard, rf_we;
  logic [4:0]  rf_wreg;
  logic [31:0] rf_wdata;
`ifdef RF_SCHED_BYPASS_EN
  logic        byp_rs, byp_rt;
  logic [31:0] byp_data;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          pend_m [32];
  int          losses;
  bit          forced;
  bit          m_we;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;

  logic obs_wb, obs_lu, obs_haz;

  always #5 clk = ~clk;

  rf_write_sched #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ready(wb_ready),
    .lu_valid(lu_valid), .lu_reg(lu_reg), .lu_data(lu_data), .lu_ready(lu_ready),
    .iss_valid(iss_valid), .iss_reg(iss_reg), .iss_ready(iss_ready),
    .rs(rs), .rt(rt), .hazard(hazard),
    .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata)
`ifdef RF_SCHED_BYPASS_EN
    , .byp_rs(byp_rs), .byp_rt(byp_rt), .byp_data(byp_data)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    losses  = 0;
    forced  = 1'b0;
    m_we    = 1'b0;
    m_wreg  = '0;
    m_wdata = '0;
  endtask

  task automatic idle();
    wb_valid = 0; lu_valid = 0; iss_valid = 0;
    wb_reg = 0; lu_reg = 0; iss_reg = 0; rs = 0; rt = 0;
    wb_data = 0; lu_data = 0;
  endtask

  // One clock: check same-cycle outputs mid-cycle, advance the model, check write port after the edge.
  task automatic step(input string tag);
    bit ew, el, ei, eh, ebrs, ebrt;
    #4;
    if (forced && lu_valid)  begin el = 1; ew = 0; end
    else if (wb_valid)       begin ew = 1; el = 0; end
    else                     begin ew = 0; el = lu_valid; end
    ei = !pend_m[iss_reg];
    ebrs = 0; ebrt = 0;
`ifdef RF_SCHED_BYPASS_EN
    ebrs = el && lu_reg != 0 && lu_reg == rs;
    ebrt = el && lu_reg != 0 && lu_reg == rt;
    chk({tag, ".byp_rs"}, 32'(byp_rs), 32'(ebrs));
    chk({tag, ".byp_rt"}, 32'(byp_rt), 32'(ebrt));
    if (ebrs || ebrt) chk({tag, ".byp_data"}, byp_data, lu_data);
`endif
    eh = (rs != 0 && pend_m[rs] && !ebrs) || (rt != 0 && pend_m[rt] && !ebrt);
    obs_wb = wb_ready; obs_lu = lu_ready; obs_haz = hazard;
    chk({tag, ".wb_ready"},  32'(wb_ready),  32'(ew));
    chk({tag, ".lu_ready"},  32'(lu_ready),  32'(el));
    chk({tag, ".iss_ready"}, 32'(iss_ready), 32'(ei));
    chk({tag, ".hazard"},    32'(hazard),    32'(eh));
    if (el) begin losses = 0; forced = 0; end
    else if (lu_valid) begin losses++; if (losses >= LIMIT) forced = 1; end
    else losses = 0;
    if (el && lu_reg != 0) pend_m[lu_reg] = 1'b0;
    if (iss_valid && ei && iss_reg != 0) pend_m[iss_reg] = 1'b1;
    if (ew && wb_reg != 0)      begin m_we = 1; m_wreg = wb_reg; m_wdata = wb_data; end
    else if (el && lu_reg != 0) begin m_we = 1; m_wreg = lu_reg; m_wdata = lu_data; end
    else m_we = 0;
    @(posedge clk);
    #1;
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(m_we));
    if (m_we) begin
      chk({tag, ".rf_wreg"},  32'(rf_wreg), 32'(m_wreg));
      chk({tag, ".rf_wdata"}, rf_wdata, m_wdata);
    end
  endtask

  initial begin
    idle();
    model_reset();
    reset = 1'b1;
    #12 reset = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("rst.rf_wreg",  32'(rf_wreg), 32'd0);
    chk("rst.rf_wdata", rf_wdata, 32'd0);
    step("rst_idle");

    // WB and long unit contending: WB x4, long unit, then WB again
    wb_valid = 1; wb_reg = 5'd1; lu_valid = 1; lu_reg = 5'd2;
    for (int i = 0; i < 6; i++) begin
      wb_data = 32'h100 + 32'(i); lu_data = 32'h200 + 32'(i);
      step($sformatf("starve%0d", i));
      chk($sformatf("starve%0d.lu_slot", i), 32'(obs_lu), 32'(i == 4));
      chk($sformatf("starve%0d.wb_slot", i), 32'(obs_wb), 32'(i != 4));
    end
    idle();
    step("starve_idle");

    // Issue r9, read it, complete it
    iss_valid = 1; iss_reg = 5'd9;
    step("iss9");
    iss_valid = 0; rs = 5'd9;
    step("haz9");
    chk("haz9.pending", 32'(obs_haz), 32'd1);
    iss_valid = 1; iss_reg = 5'd9;
    step("iss9_stall");
    iss_valid = 0;
    lu_valid = 1; lu_reg = 5'd9; lu_data = 32'hCAFE_0009;
    step("lu9");
    chk("lu9.rf_wreg", 32'(rf_wreg), 32'd9);
    lu_valid = 0;
    step("haz9_clear");
    chk("haz9_clear.hazard", 32'(obs_haz), 32'd0);

    // Same-cycle issue and completion of r9: issue wins
    iss_valid = 1; iss_reg = 5'd9; lu_valid = 1; lu_reg = 5'd9; lu_data = 32'h99;
    step("iss_lu_same");
    iss_valid = 0; lu_valid = 0;
    step("iss_lu_after");
    chk("iss_lu_after.hazard", 32'(obs_haz), 32'd1);
    lu_valid = 1; lu_data = 32'h9A;
    step("lu9_final");
    lu_valid = 0;

    // r0 handling
    wb_valid = 1; wb_reg = 5'd0; wb_data = 32'hDEADBEEF;
    step("wb_r0");
    chk("wb_r0.rf_we", 32'(rf_we), 32'd0);
    wb_valid = 0; iss_valid = 1; iss_reg = 5'd0; rs = 5'd0;
    step("iss_r0");
    iss_valid = 0;
    step("iss_r0_after");

`ifdef RF_SCHED_BYPASS_EN
    iss_valid = 1; iss_reg = 5'd5;
    step("iss5");
    iss_valid = 0; lu_valid = 1; lu_reg = 5'd5; lu_data = 32'h1234; rt = 5'd5;
    step("byp5");
    chk("byp5.hazard", 32'(obs_haz), 32'd0);
    idle();
`endif

    // Asynchronous reset mid-stream with r8 pending and a write in flight
    iss_valid = 1; iss_reg = 5'd8; wb_valid = 1; wb_reg = 5'd3; wb_data = 32'h3333;
    step("pre_rst");
    idle(); rs = 5'd8;
    #1;
    chk("pre_rst.hazard", 32'(hazard), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst.rf_we",    32'(rf_we), 32'd0);
    chk("async_rst.rf_wreg",  32'(rf_wreg), 32'd0);
    chk("async_rst.rf_wdata", rf_wdata, 32'd0);
    chk("async_rst.hazard",   32'(hazard), 32'd0);
    #2 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    step("post_rst");

    // Random traffic on a small register window to force collisions
    for (int n = 0; n < 400; n++) begin
      wb_valid  = 1'($urandom_range(0, 1));
      lu_valid  = 1'($urandom_range(0, 1));
      iss_valid = 1'($urandom_range(0, 1));
      wb_reg    = 5'($urandom_range(0, 7));
      lu_reg    = 5'($urandom_range(0, 7));
      iss_reg   = 5'($urandom_range(0, 7));
      rs        = 5'($urandom_range(0, 7));
      rt        = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      lu_data   = $urandom;
      step($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
